// File: rtl/piso_tx_if.sv
// Handshake and serial-side bundle for piso_tx: parallel words in, one bit per enabled clock out.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             so_en;
    logic             so;
    logic             so_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output din, din_valid, so_en,
        input  din_ready, so, so_valid, frame_start, busy
    );

    modport slave (
        input  din, din_valid, so_en,
        output din_ready, so, so_valid, frame_start, busy
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer, so back-to-back words
// leave with no idle bit between them; frame_start marks the first bit of every word.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic      clk,
    input logic      clear_n,
    piso_tx_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             so_r;
    logic             so_valid_r;
    logic             frame_start_r;

    logic accept;
    logic last_taken;

    // Bit presented first out of a freshly loaded or freshly shifted word.
    function automatic logic lead(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign accept     = bus.din_valid && !hold_full;
    assign last_taken = (state == SHIFT) && bus.so_en && (cnt == LAST);

    assign bus.din_ready   = !hold_full;
    assign bus.so          = so_r;
    assign bus.so_valid    = so_valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.busy        = (state == SHIFT) || hold_full;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_full     <= 1'b0;
            so_r          <= 1'b0;
            so_valid_r    <= 1'b0;
            frame_start_r <= 1'b0;
            // NOTE: the data registers are cleared as well, so no bit of a discarded word can resurface.
            shreg         <= '0;
            hold          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg         <= bus.din;
                        so_r          <= lead(bus.din);
                        so_valid_r    <= 1'b1;
                        frame_start_r <= 1'b1;
                        cnt           <= '0;
                        state         <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bus.so_en) begin
                        if (cnt != LAST) begin
                            shreg         <= advance(shreg);
                            so_r          <= lead(advance(shreg));
                            cnt           <= cnt + 1'b1;
                            frame_start_r <= 1'b0;
                        end else if (hold_full) begin
                            shreg         <= hold;
                            so_r          <= lead(hold);
                            cnt           <= '0;
                            frame_start_r <= 1'b1;
                            hold_full     <= 1'b0;
                        end else if (accept) begin
                            // Bypass: the word arriving on the last-bit edge skips the hold register.
                            shreg         <= bus.din;
                            so_r          <= lead(bus.din);
                            cnt           <= '0;
                            frame_start_r <= 1'b1;
                        end else begin
                            state         <= IDLE;
                            so_r          <= 1'b0;
                            so_valid_r    <= 1'b0;
                            frame_start_r <= 1'b0;
                        end
                    end

                    // A stalled or mid-word accept parks the word until the current one drains.
                    if (accept && !last_taken) begin
                        hold      <= bus.din;
                        hold_full <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
